diff_clock_buffer: RTL and testbench

- Clock-entry block for the physical platform layer.
- Converts a differential board reference clock into a single-ended, globally buffered clock.
- Produces a reset for that clock domain: asserted asynchronously, released synchronously.
- Sits between the board pins and all logic clocked by the platform reference clock.

---
 rtl/diff_clock_buffer_pkg.sv | 18 +
 rtl/diff_clock_buffer_rst_sync_n.sv | 35 +++
 rtl/diff_clock_buffer.sv | 52 +++++
 tb/tb_diff_clock_buffer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/diff_clock_buffer_pkg.sv
// Shared constants and helpers for the platform reference-clock entry block.
// Holds the synchronizer depth limits, the reset polarity and the pair-validity rule.
package diff_clock_buffer_pkg;

   localparam int   SYNC_STAGES_MIN = 2;
   localparam int   SYNC_STAGES_MAX = 8;
   localparam logic RST_ACTIVE      = 1'b0;

   // A differential pair carries a clock level only while its legs disagree.
   function automatic logic diff_pair_valid(input logic p, input logic n);
      return p ^ n;
   endfunction

   function automatic bit sync_stages_legal(input int stages);
      return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
   endfunction

endpackage

// File: rtl/diff_clock_buffer_rst_sync_n.sv
// Generic active-low reset synchronizer: asserts asynchronously, releases after
// STAGES rising clock edges with the input deasserted.
module rst_sync_n
   import diff_clock_buffer_pkg::*;
#(
   parameter int STAGES = 3
) (
   input  logic clk,
   input  logic rst_n,
   output logic rst_n_sync
);

   if (!sync_stages_legal(STAGES)) begin : g_bad_stages
      $error("rst_sync_n: STAGES=%0d outside %0d..%0d", STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
   end

   logic [STAGES-1:0] sync_d;
   logic [STAGES-1:0] sync_q;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], 1'b1};
   end

   // Every stage clears together, so a re-assertion mid-release restarts the full count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (rst_n == RST_ACTIVE) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign rst_n_sync = sync_q[STAGES-1];

endmodule

// File: rtl/diff_clock_buffer.sv
// Clock-entry block: differential reference clock to a single-ended global clock,
// plus an async-assert / sync-release reset for that clock domain.
module diff_clock_buffer
   import diff_clock_buffer_pkg::*;
#(
   parameter int SYNC_STAGES = 3,
   parameter int DIFF_TERM   = 0
) (
   input  logic CLK_P_IN,
   input  logic CLK_N_IN,
   input  logic RST_N_IN,
   output logic CLK_OUT,
   output logic RST_N_OUT,
   output logic DIFF_ERR
);

   if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync_stages
      $error("diff_clock_buffer: SYNC_STAGES=%0d outside %0d..%0d",
             SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
   end

   if ((DIFF_TERM != 0) && (DIFF_TERM != 1)) begin : g_bad_diff_term
      $error("diff_clock_buffer: DIFF_TERM=%0d must be 0 or 1", DIFF_TERM);
   end

   logic pair_valid;
   logic clk_rx;
   logic clk_glb;

   assign pair_valid = diff_pair_valid(CLK_P_IN, CLK_N_IN);
   assign DIFF_ERR   = ~pair_valid;

   // Receive stage: follows P while the pair is valid, holds its level through P==N.
   always_latch begin
      if (pair_valid) begin
         clk_rx <= CLK_P_IN;
      end
   end

   // Global buffer stage: a plain wire in simulation, a clock-tree buffer in the netlist.
   assign clk_glb = clk_rx;
   assign CLK_OUT = clk_glb;

   rst_sync_n #(
      .STAGES(SYNC_STAGES)
   ) u_rst_sync (
      .clk       (clk_glb),
      .rst_n     (RST_N_IN),
      .rst_n_sync(RST_N_OUT)
   );

endmodule

// File: tb/tb_diff_clock_buffer.sv
// Directed bench for diff_clock_buffer (SYNC_STAGES=3): clock pass-through,
// reset release latency, async pulses, stopped clock and partial-release restart.
`timescale 1ns / 100ps
module tb_diff_clock_buffer;

   logic phase;
   logic stopped;
   logic stopVal;
   logic clkP;
   logic clkN;
   logic rstNIn;
   logic clkOut;
   logic rstNOut;
   logic diffErr;

   int checks;
   int errors;

   diff_clock_buffer #(
      .SYNC_STAGES(3),
      .DIFF_TERM  (0)
   ) dut (
      .CLK_P_IN (clkP),
      .CLK_N_IN (clkN),
      .RST_N_IN (rstNIn),
      .CLK_OUT  (clkOut),
      .RST_N_OUT(rstNOut),
      .DIFF_ERR (diffErr)
   );

   // Free-running 100 MHz reference: rising P edges at 5, 15, 25 ... ns.
   initial phase = 1'b0;
   always #5 phase = ~phase;

   // Stopping the clock forces both legs to the same level.
   assign clkP = stopped ? stopVal : phase;
   assign clkN = stopped ? stopVal : ~phase;

   task automatic waitTo(input real t);
      if (t > $realtime) #(t - $realtime);
   endtask

   task automatic applyStimulus(input real t, input logic rst, input logic stop, input logic stopLevel);
      waitTo(t);
      rstNIn  = rst;
      stopped = stop;
      stopVal = stopLevel;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $realtime, observed, expected);
      end
   endtask

   task automatic checkRstAt(input real t, input string tag, input logic expected);
      waitTo(t);
      checkOutput(tag, {31'd0, rstNOut}, {31'd0, expected});
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      applyStimulus(0.0, 1'b0, 1'b0, 1'b0);

      // Reset state and time-zero clock level.
      waitTo(1.0);
      checkOutput("resetRstOut", {31'd0, rstNOut}, 32'd0);
      checkOutput("resetClkOut", {31'd0, clkOut}, 32'd0);
      checkOutput("resetDiffErr", {31'd0, diffErr}, 32'd0);

      // CLK_OUT tracks P: high between rising and falling edges, low otherwise.
      for (int k = 1; k <= 9; k++) begin
         waitTo(2.0 + 5.0 * k);
         checkOutput("clkFollowsP", {31'd0, clkOut}, {31'd0, (k % 2 == 1)});
         checkOutput("diffErrIdle", {31'd0, diffErr}, 32'd0);
      end

      // Off-edge release at 52 ns: rises on the 3rd edge (75 ns).
      applyStimulus(52.0, 1'b1, 1'b0, 1'b0);
      checkRstAt(53.0, "releaseNoEdge", 1'b0);
      checkRstAt(57.0, "releaseEdge1", 1'b0);
      checkRstAt(67.0, "releaseEdge2", 1'b0);
      checkRstAt(74.0, "releaseBefore3", 1'b0);
      checkRstAt(76.0, "releaseEdge3", 1'b1);

      // 2 ns async pulse between edges drops the output immediately.
      applyStimulus(78.0, 1'b0, 1'b0, 1'b0);
      checkRstAt(78.5, "pulseAsyncDrop", 1'b0);
      applyStimulus(80.0, 1'b1, 1'b0, 1'b0);
      checkRstAt(81.0, "pulseAfter", 1'b0);
      checkRstAt(86.0, "pulseEdge1", 1'b0);
      checkRstAt(96.0, "pulseEdge2", 1'b0);
      checkRstAt(104.0, "pulseBefore3", 1'b0);
      checkRstAt(106.0, "pulseEdge3", 1'b1);

      // P=N=1 while CLK_OUT is high: clock holds 1, DIFF_ERR raised.
      applyStimulus(107.0, 1'b1, 1'b1, 1'b1);
      waitTo(108.0);
      checkOutput("stopDiffErr", {31'd0, diffErr}, 32'd1);
      checkOutput("stopClkHold", {31'd0, clkOut}, 32'd1);
      waitTo(116.0);
      checkOutput("stopClkHold2", {31'd0, clkOut}, 32'd1);
      checkOutput("stopRstFrozen", {31'd0, rstNOut}, 32'd1);

      // Reset asserted while the clock is stopped still lands, and sticks until edges resume.
      applyStimulus(120.0, 1'b0, 1'b1, 1'b1);
      checkRstAt(121.0, "stopAsyncAssert", 1'b0);
      applyStimulus(125.0, 1'b1, 1'b1, 1'b1);
      checkRstAt(130.0, "stopNoRelease", 1'b0);
      waitTo(136.0);
      checkOutput("stopDiffErrEnd", {31'd0, diffErr}, 32'd1);
      checkOutput("stopClkHoldEnd", {31'd0, clkOut}, 32'd1);
      checkOutput("stopRstStill0", {31'd0, rstNOut}, 32'd0);

      // Complementary drive resumes at 137 ns with P already high.
      applyStimulus(137.0, 1'b1, 1'b0, 1'b0);
      waitTo(138.0);
      checkOutput("resumeDiffErr", {31'd0, diffErr}, 32'd0);
      checkOutput("resumeClkHigh", {31'd0, clkOut}, 32'd1);
      waitTo(142.0);
      checkOutput("resumeClkLow", {31'd0, clkOut}, 32'd0);
      checkRstAt(146.0, "resumeEdge1", 1'b0);
      checkRstAt(156.0, "resumeEdge2", 1'b0);
      checkRstAt(164.0, "resumeBefore3", 1'b0);
      checkRstAt(166.0, "resumeEdge3", 1'b1);

      // Partial release (one edge at 175) then re-assert: second release needs 3 fresh edges.
      applyStimulus(170.0, 1'b0, 1'b0, 1'b0);
      applyStimulus(172.0, 1'b1, 1'b0, 1'b0);
      applyStimulus(177.0, 1'b0, 1'b0, 1'b0);
      checkRstAt(178.0, "partialCleared", 1'b0);
      applyStimulus(182.0, 1'b1, 1'b0, 1'b0);
      checkRstAt(186.0, "restartEdge1", 1'b0);
      checkRstAt(196.0, "restartEdge2", 1'b0);
      checkRstAt(204.0, "restartBefore3", 1'b0);
      checkRstAt(206.0, "restartEdge3", 1'b1);

      // Release on the 215 ns edge: rise at 235 or 245 are both acceptable.
      applyStimulus(210.0, 1'b0, 1'b0, 1'b0);
      applyStimulus(215.0, 1'b1, 1'b0, 1'b0);
      checkRstAt(234.0, "edgeReleaseEarly", 1'b0);
      checkRstAt(246.0, "edgeReleaseLate", 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
